// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: address width,
// FSM state and flush-kind encodings, and pipeline stage indices.
package pipeline_ctrl_pkg;

    // Width of every PC-sized bus (exception targets, redirect targets).
    localparam int ADDR_W = 32;

    // Stage indices. Index 0 is the oldest frontend stage.
    localparam int STAGE_IF    = 0;
    localparam int STAGE_ID    = 1;
    localparam int STAGE_ROB   = 2;
    localparam int STAGE_ISSUE = 3;
    localparam int STAGE_EXEC  = 4;

    typedef enum logic [1:0] {
        PCTRL_RUN      = 2'd0,
        PCTRL_FLUSH    = 2'd1,
        PCTRL_REDIRECT = 2'd2,
        PCTRL_RECOVER  = 2'd3
    } pctrl_state_e;

    // MISP is the reset value of the latched kind.
    typedef enum logic {
        FLUSH_KIND_MISP = 1'b0,
        FLUSH_KIND_EXC  = 1'b1
    } flush_kind_e;

endpackage

// File: rtl/pipeline_ctrl_stall_suffix_or.sv
// Suffix-OR of per-stage stall requests: a stalled stage also holds every
// older (lower-index) stage behind it.
module stall_suffix_or #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [WIDTH-1:0] stall_o
);

    logic acc;

    // Walk from the youngest stage down, accumulating any stall seen so far.
    always_comb begin
        acc     = 1'b0;
        stall_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc        = acc | req_i[i];
            stall_o[i] = acc;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer. Converts stage stall requests into a
// back-propagating stall vector, and exception/mispredict events into a
// one-cycle flush, a PC redirect offered to fetch, and a recovery window
// during which the frontend is held.
//
// Redirect handshake: redirect_valid/redirect_pc form a valid/ready pair with
// fetch. A transfer happens on a clock edge where redirect_valid and
// redirect_ready are both high. Once valid is raised it stays high and
// redirect_pc stays stable until that transfer, unless an exception
// overrides the pending redirect by re-entering FLUSH with a new target.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int STAGE_NUM       = 5,
    parameter int FRONTEND_STAGES = 2,
    parameter int RECOVERY_CYCLES = 2,
    parameter int REC_CNT_WIDTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STAGE_NUM-1:0] stall_req,
    input  logic                 exc_req,
    input  logic [ADDR_W-1:0]    exc_pc,
    input  logic                 mispredict_req,
    input  logic [ADDR_W-1:0]    mispredict_pc,
    input  logic                 redirect_ready,
    output logic [STAGE_NUM-1:0] stall,
    output logic [STAGE_NUM-1:0] flush,
    output logic                 redirect_valid,
    output logic [ADDR_W-1:0]    redirect_pc,
    output logic                 busy
);

    pctrl_state_e             state_q, state_d;
    flush_kind_e              kind_q, kind_d;
    logic [ADDR_W-1:0]        target_q, target_d;
    logic [REC_CNT_WIDTH-1:0] rec_cnt_q, rec_cnt_d;

    logic [STAGE_NUM-1:0]     base_stall;
    logic [STAGE_NUM-1:0]     fe_mask;

    stall_suffix_or #(
        .WIDTH (STAGE_NUM)
    ) u_suffix (
        .req_i   (stall_req),
        .stall_o (base_stall)
    );

    // Constant mask of the frontend stages, flushed on mispredict and held
    // while a redirect is pending or recovering.
    always_comb begin
        fe_mask = '0;
        for (int i = 0; i < STAGE_NUM; i++) begin
            fe_mask[i] = (i < FRONTEND_STAGES);
        end
    end

    // State register with synchronous reset; a pending redirect is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PCTRL_RUN;
            kind_q    <= FLUSH_KIND_MISP;
            target_q  <= '0;
            rec_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            target_q  <= target_d;
            rec_cnt_q <= rec_cnt_d;
        end
    end

    // Next-state logic. Exceptions are older than anything in flight, so they
    // always restart the sequence; a mispredict is only taken from RUN.
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        target_d  = target_q;
        rec_cnt_d = rec_cnt_q;

        if (exc_req) begin
            state_d  = PCTRL_FLUSH;
            kind_d   = FLUSH_KIND_EXC;
            target_d = exc_pc;
        end else begin
            case (state_q)
                PCTRL_RUN: begin
                    if (mispredict_req) begin
                        state_d  = PCTRL_FLUSH;
                        kind_d   = FLUSH_KIND_MISP;
                        target_d = mispredict_pc;
                    end
                end
                PCTRL_FLUSH, PCTRL_REDIRECT: begin
                    if (redirect_ready) begin
                        if (RECOVERY_CYCLES == 0) begin
                            state_d = PCTRL_RUN;
                        end else begin
                            state_d   = PCTRL_RECOVER;
                            rec_cnt_d = REC_CNT_WIDTH'(RECOVERY_CYCLES);
                        end
                    end else begin
                        state_d = PCTRL_REDIRECT;
                    end
                end
                PCTRL_RECOVER: begin
                    if (rec_cnt_q <= REC_CNT_WIDTH'(1)) begin
                        state_d   = PCTRL_RUN;
                        rec_cnt_d = '0;
                    end else begin
                        rec_cnt_d = rec_cnt_q - 1'b1;
                    end
                end
                default: state_d = PCTRL_RUN;
            endcase
        end
    end

    // Output decode from the current state; everything is forced low while
    // reset is asserted.
    always_comb begin
        stall          = '0;
        flush          = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        busy           = 1'b0;

        if (!rst) begin
            busy = (state_q != PCTRL_RUN);
            case (state_q)
                PCTRL_RUN: begin
                    stall = base_stall;
                end
                PCTRL_FLUSH: begin
                    flush          = (kind_q == FLUSH_KIND_EXC) ? '1 : fe_mask;
                    redirect_valid = 1'b1;
                    redirect_pc    = target_q;
                end
                PCTRL_REDIRECT: begin
                    stall          = base_stall | fe_mask;
                    redirect_valid = 1'b1;
                    redirect_pc    = target_q;
                end
                PCTRL_RECOVER: begin
                    stall = base_stall | fe_mask;
                end
                default: begin
                    stall = base_stall;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: stall suffix-OR, mispredict and exception
// sequences, redirect back-pressure, event overlap, reset mid-sequence, and a
// second instance with no recovery window.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  stall_req;
    logic        exc_req;
    logic [31:0] exc_pc;
    logic        mispredict_req;
    logic [31:0] mispredict_pc;
    logic        redirect_ready;

    logic [4:0]  stall, flush;
    logic        redirect_valid, busy;
    logic [31:0] redirect_pc;

    logic [4:0]  stall0, flush0;
    logic        redirect_valid0, busy0;
    logic [31:0] redirect_pc0;

    int total = 0;
    int bad   = 0;

    pipeline_ctrl #(
        .STAGE_NUM(5), .FRONTEND_STAGES(2), .RECOVERY_CYCLES(2), .REC_CNT_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req),
        .exc_req(exc_req), .exc_pc(exc_pc),
        .mispredict_req(mispredict_req), .mispredict_pc(mispredict_pc),
        .redirect_ready(redirect_ready),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    pipeline_ctrl #(
        .STAGE_NUM(5), .FRONTEND_STAGES(2), .RECOVERY_CYCLES(0), .REC_CNT_WIDTH(2)
    ) dut0 (
        .clk(clk), .rst(rst), .stall_req(stall_req),
        .exc_req(exc_req), .exc_pc(exc_pc),
        .mispredict_req(mispredict_req), .mispredict_pc(mispredict_pc),
        .redirect_ready(redirect_ready),
        .stall(stall0), .flush(flush0), .redirect_valid(redirect_valid0),
        .redirect_pc(redirect_pc0), .busy(busy0)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_rv"}, {31'd0, redirect_valid}, 32'd0);
        check({tag, "_flush"}, {27'd0, flush}, 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        stall_req      = 5'b11111;
        exc_req        = 1'b0;
        exc_pc         = '0;
        mispredict_req = 1'b0;
        mispredict_pc  = '0;
        redirect_ready = 1'b0;
        cyc();
        cyc();
        settle();
        // Reset: stall gated even with every stage requesting.
        check("rst_stall", {27'd0, stall}, 32'd0);
        check_idle("rst");
        check("rst_rpc", redirect_pc, 32'd0);

        // 1. Stall suffix-OR in RUN.
        rst = 1'b0;
        stall_req = 5'b00100; settle();
        check("st_00100", {27'd0, stall}, 32'h07);
        check_idle("st");
        stall_req = 5'b10010; settle();
        check("st_10010", {27'd0, stall}, 32'h1f);
        stall_req = 5'b00001; settle();
        check("st_00001", {27'd0, stall}, 32'h01);
        stall_req = 5'b01000; settle();
        check("st_01000", {27'd0, stall}, 32'h0f);
        stall_req = 5'b00000; settle();
        check("st_none", {27'd0, stall}, 32'h00);

        // 2. Mispredict, redirect accepted immediately.
        redirect_ready = 1'b1;
        mispredict_req = 1'b1; mispredict_pc = 32'h8000_0100; settle();
        check("m_req_busy", {31'd0, busy}, 32'd0);
        cyc();
        mispredict_req = 1'b0; settle();
        check("m_flush", {27'd0, flush}, 32'h03);
        check("m_rv", {31'd0, redirect_valid}, 32'd1);
        check("m_rpc", redirect_pc, 32'h8000_0100);
        check("m_fl_stall", {27'd0, stall}, 32'h00);
        check("m_fl_busy", {31'd0, busy}, 32'd1);
        cyc();
        stall_req = 5'b01000; settle();
        check("m_rec1_stall", {27'd0, stall}, 32'h0f);
        check("m_rec1_rv", {31'd0, redirect_valid}, 32'd0);
        check("m_rec1_busy", {31'd0, busy}, 32'd1);
        cyc();
        stall_req = 5'b00000; settle();
        check("m_rec2_stall", {27'd0, stall}, 32'h03);
        check("m_rec2_busy", {31'd0, busy}, 32'd1);
        cyc(); settle();
        check("m_run_stall", {27'd0, stall}, 32'h00);
        check_idle("m_run");

        // 3. Exception with fetch back-pressure.
        redirect_ready = 1'b0;
        exc_req = 1'b1; exc_pc = 32'hBFC0_0380;
        cyc();
        exc_req = 1'b0; settle();
        check("e_flush", {27'd0, flush}, 32'h1f);
        check("e_rv", {31'd0, redirect_valid}, 32'd1);
        check("e_rpc", redirect_pc, 32'hBFC0_0380);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            if (k == 3) redirect_ready = 1'b1;
            settle();
            check($sformatf("e_rd%0d_rv", k), {31'd0, redirect_valid}, 32'd1);
            check($sformatf("e_rd%0d_rpc", k), redirect_pc, 32'hBFC0_0380);
            check($sformatf("e_rd%0d_flush", k), {27'd0, flush}, 32'h00);
            check($sformatf("e_rd%0d_stall", k), {27'd0, stall}, 32'h03);
        end
        cyc(); settle();
        check("e_rec1_rv", {31'd0, redirect_valid}, 32'd0);
        check("e_rec1_busy", {31'd0, busy}, 32'd1);
        cyc(); settle();
        check("e_rec2_busy", {31'd0, busy}, 32'd1);
        cyc(); settle();
        check_idle("e_run");

        // 4. Simultaneous exception and mispredict: exception wins.
        exc_req = 1'b1; exc_pc = 32'h0000_1000;
        mispredict_req = 1'b1; mispredict_pc = 32'h0000_2000;
        cyc();
        exc_req = 1'b0; mispredict_req = 1'b0; settle();
        check("both_flush", {27'd0, flush}, 32'h1f);
        check("both_rpc", redirect_pc, 32'h0000_1000);
        cyc(); cyc(); cyc(); settle();
        check_idle("both_run");

        // 5a. Mispredict during RECOVER is ignored.
        mispredict_req = 1'b1; mispredict_pc = 32'h0000_3000;
        cyc();
        mispredict_req = 1'b0; settle();
        check("mr_flush", {27'd0, flush}, 32'h03);
        cyc();
        mispredict_req = 1'b1; mispredict_pc = 32'h0000_4000; settle();
        check("mr_rec1_busy", {31'd0, busy}, 32'd1);
        check("mr_rec1_rv", {31'd0, redirect_valid}, 32'd0);
        cyc();
        mispredict_req = 1'b0; settle();
        check("mr_rec2_busy", {31'd0, busy}, 32'd1);
        check("mr_rec2_flush", {27'd0, flush}, 32'h00);
        cyc(); settle();
        check_idle("mr_run");

        // 5b. Exception during REDIRECT overrides the pending target.
        redirect_ready = 1'b0;
        exc_req = 1'b1; exc_pc = 32'h0000_5000;
        cyc();
        exc_req = 1'b0;
        cyc(); settle();
        check("er_rd_rpc", redirect_pc, 32'h0000_5000);
        check("er_rd_flush", {27'd0, flush}, 32'h00);
        exc_req = 1'b1; exc_pc = 32'h0000_6000; settle();
        check("er_rd_hold", redirect_pc, 32'h0000_5000);
        cyc();
        exc_req = 1'b0; settle();
        check("er_fl_flush", {27'd0, flush}, 32'h1f);
        check("er_fl_rpc", redirect_pc, 32'h0000_6000);
        check("er_fl_rv", {31'd0, redirect_valid}, 32'd1);
        redirect_ready = 1'b1;
        cyc(); cyc(); cyc(); settle();
        check_idle("er_run");

        // 6. Reset while in REDIRECT.
        redirect_ready = 1'b0;
        exc_req = 1'b1; exc_pc = 32'h0000_7000;
        cyc();
        exc_req = 1'b0;
        cyc(); settle();
        check("rr_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1; stall_req = 5'b11111; settle();
        check("rr_rst_stall", {27'd0, stall}, 32'd0);
        check("rr_rst_rpc", redirect_pc, 32'd0);
        check_idle("rr_rst");
        cyc(); settle();
        check_idle("rr_rst2");
        rst = 1'b0; stall_req = 5'b00000; settle();
        check_idle("rr_after");
        check("rr_after_stall", {27'd0, stall}, 32'd0);

        // 6b. No recovery window: FLUSH returns straight to RUN on ready.
        redirect_ready = 1'b1;
        mispredict_req = 1'b1; mispredict_pc = 32'h0000_8000;
        cyc();
        mispredict_req = 1'b0; settle();
        check("z_fl_flush", {27'd0, flush0}, 32'h03);
        check("z_fl_rpc", redirect_pc0, 32'h0000_8000);
        check("z_fl_busy", {31'd0, busy0}, 32'd1);
        cyc();
        stall_req = 5'b00010; settle();
        check("z_run_busy", {31'd0, busy0}, 32'd0);
        check("z_run_stall", {27'd0, stall0}, 32'h03);
        check("z_run_rv", {31'd0, redirect_valid0}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
